apb_ram_param: RTL and testbench
================================

APB_RAM_PARAM -- requirements
Module: apb_ram_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width in bits (multiple of 8, 8..64).
REQ-002 SHALL have parameter DEPTH, default 32, number of DATA_W-bit words (2..1024).
REQ-003 SHALL have parameter WAIT_STATES, default 0, extra access-phase cycles before pready (0..15).
REQ-004 SHALL have port pclk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port presetn, input, 1, reset, synchronous, active-low.
REQ-006 SHALL have ports psel, penable, pwrite, inputs, 1 each, APB select/enable/direction.
REQ-007 SHALL have port paddr, input, 32, word index (not byte address).
REQ-008 SHALL have port pwdata, input, DATA_W, write data.
REQ-009 SHALL have port pstrb, input, DATA_W/8, byte-lane write strobes (present only with APB_RAM_STRB_EN).
REQ-010 SHALL have ports prdata (output, DATA_W), pready (output, 1), pslverr (output, 1), all registered.

Function
REQ-011 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE; illegal/unknown state SHALL return to IDLE.
REQ-012 IDLE: on psel=1, penable=0 (setup phase), SHALL latch paddr, pwrite, pwdata (and pstrb), clear wait counter, go ACCESS.
REQ-013 ACCESS: each cycle with psel=1, penable=1 and counter < WAIT_STATES SHALL increment counter, stay ACCESS, pready=0.
REQ-014 ACCESS: at the edge with psel=1, penable=1 and counter == WAIT_STATES SHALL execute the transfer, set pready=1, go DONE.
REQ-015 pready SHALL be high for exactly one cycle (the DONE cycle); transfer latency = WAIT_STATES+1 access-phase cycles plus the DONE cycle.
REQ-016 DONE: SHALL clear pready and pslverr and go IDLE; prdata SHALL hold its value until the next read executes.
REQ-017 Write with latched addr < DEPTH SHALL update mem[addr] at the execute edge, pslverr=0.
REQ-018 Read with latched addr < DEPTH SHALL load prdata with mem[addr] at the execute edge, pslverr=0.
REQ-019 Access with addr >= DEPTH SHALL not modify memory, SHALL set pslverr=1 with pready, and a read SHALL drive prdata to all zeros.
REQ-020 psel deasserted while in ACCESS SHALL abort: no memory write, no pready, go IDLE.
REQ-021 In ACCESS, psel=1 with penable=0 SHALL hold state and counter (no execute).
REQ-022 Back-to-back transfers SHALL be accepted: a setup phase sampled in the cycle after DONE starts a new transfer.

Reset
REQ-023 presetn=0 at a rising edge SHALL force state IDLE, counter 0, prdata 0, pready 0, pslverr 0.
REQ-024 presetn=0 SHALL clear all DEPTH memory words to 0 at that edge.
REQ-025 Reset during ACCESS or DONE SHALL abort the transfer with no memory update and no pready pulse.

Configuration
REQ-026 Macro APB_RAM_STRB_EN defined: pstrb port present; write updates only bytes whose strobe bit is 1; pstrb all zero SHALL leave memory unchanged with pslverr=0.
REQ-027 Macro APB_RAM_STRB_EN undefined: no pstrb port; every write updates the full DATA_W word.

Verification
REQ-028 Reset then read addr 5 (DATA_W=32, WAIT_STATES=0) -> prdata=0x00000000, pready one cycle, pslverr=0.
REQ-029 Write 0xDEADBEEF to addr 3 then read addr 3 -> prdata=0xDEADBEEF, pslverr=0 on both.
REQ-030 WAIT_STATES=3, write addr 1 -> pready rises after exactly 4 access-phase cycles, high 1 cycle.
REQ-031 Write addr 32 with DEPTH=32, then read 32 -> pslverr=1 both, prdata=0, mem[0..31] unchanged.
REQ-032 STRB_EN: write 0xFFFFFFFF to addr 7, then 0x11223344 with pstrb=4'b0101 -> read 0xFF22FF44.
REQ-033 Deassert psel mid-ACCESS on write to addr 2 (WAIT_STATES=2), or assert presetn=0 mid-ACCESS -> no pready, read addr 2 returns prior value.

Source files
------------

// File: rtl/apb_ram_param.sv
// apb_ram_param: APB word-addressed RAM with configurable wait states; define APB_RAM_STRB_EN to add pstrb byte-lane writes
module apb_ram_param #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [31:0]       paddr,
  input  logic [DATA_W-1:0] pwdata,
`ifdef APB_RAM_STRB_EN
  input  logic [DATA_W/8-1:0] pstrb,
`endif
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic pwrite_q;
  logic [DATA_W-1:0] wdata_q, mem_wd;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic pready_q, pready_d, pslverr_q, pslverr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic setup, access, exec, in_range, wr_en;
  logic [AW-1:0] idx;
`ifdef APB_RAM_STRB_EN
  logic [DATA_W/8-1:0] strb_q;
`endif
  assign setup    = psel & ~penable;
  assign access   = psel & penable;
  assign in_range = addr_q < 32'(DEPTH);
  assign idx      = addr_q[AW-1:0];
  assign exec     = (state_q == ACCESS) & access & (cnt_q == WS);
  assign wr_en    = exec & pwrite_q & in_range;
  // state register; any unencoded value falls back to IDLE via next-state logic
  always_ff @(posedge pclk)
    state_q <= !presetn ? IDLE : state_d;
  // next state: dropping psel mid-access aborts, penable low just stalls
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = setup ? ACCESS : IDLE;
      ACCESS:  state_d = !psel ? IDLE : exec ? DONE : ACCESS;
      default: state_d = IDLE;
    endcase
  end
  // next values of the registered outputs and the wait counter
  always_comb begin
    cnt_d     = (state_q == IDLE && setup) ? 4'd0 :
                (state_q == ACCESS && access && cnt_q < WS) ? cnt_q + 4'd1 : cnt_q;
    pready_d  = exec;
    pslverr_d = exec & ~in_range;
    prdata_d  = (exec & ~pwrite_q) ? (in_range ? mem_q[idx] : '0) : prdata_q;
  end
  // write word: untouched byte lanes keep their stored value when strobes are enabled
  always_comb begin
    mem_wd = wdata_q;
`ifdef APB_RAM_STRB_EN
    for (int b = 0; b < DATA_W/8; b++)
      mem_wd[8*b +: 8] = strb_q[b] ? wdata_q[8*b +: 8] : mem_q[idx][8*b +: 8];
`endif
  end
  // request latch at setup phase plus registered outputs
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      cnt_q     <= '0;
      addr_q    <= '0;
      pwrite_q  <= 1'b0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
`ifdef APB_RAM_STRB_EN
      strb_q    <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      if (state_q == IDLE && setup) begin
        addr_q   <= paddr;
        pwrite_q <= pwrite;
        wdata_q  <= pwdata;
`ifdef APB_RAM_STRB_EN
        strb_q   <= pstrb;
`endif
      end
    end
  end
  // storage: cleared wholesale by reset, written at the execute edge
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[idx] <= mem_wd;
    end
  end
  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;
endmodule

// File: tb/tb_apb_ram_param.sv
// tb_apb_ram_param: randomized APB transfers against a word-array reference model
module tb_apb_ram_param;
  localparam int DW = 32;
  localparam int DEPTH = 32;
  localparam int WS = 3;
`ifdef APB_RAM_STRB_EN
  localparam bit STRB = 1'b1;
`else
  localparam bit STRB = 1'b0;
`endif
  logic pclk = 1'b0;
  logic presetn, psel, penable, pwrite;
  logic [31:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic pready, pslverr;
`ifdef APB_RAM_STRB_EN
  logic [DW/8-1:0] pstrb;
`endif
  int vecs = 0;
  int errs = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] ref_rd;
  apb_ram_param #(.DATA_W(DW), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
`ifdef APB_RAM_STRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prdata), .pready(pready), .pslverr(pslverr));
  always #5 pclk = ~pclk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw, input logic [3:0] s);
    logic [DW-1:0] r;
    r = nw;
    for (int b = 0; b < DW/8; b++)
      if (STRB && !s[b]) r[8*b +: 8] = old[8*b +: 8];
    return r;
  endfunction
  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_rd = '0;
  endtask
  task automatic drive_setup(input bit wr, input logic [31:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    psel = 1'b1;
    penable = 1'b0;
    pwrite = wr;
    paddr = a;
    pwdata = d;
`ifdef APB_RAM_STRB_EN
    pstrb = s;
`else
    if (s == 4'hx) pwdata = d;
`endif
  endtask
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [DW-1:0] d, input logic [3:0] s, input bit stall);
    bit exp_err, got, pe;
    int n;
    exp_err = a >= DEPTH;
    if (wr && !exp_err) ref_mem[a] = merge(ref_mem[a], d, s);
    if (!wr) ref_rd = exp_err ? '0 : ref_mem[a];
    drive_setup(wr, a, d, s);
    @(posedge pclk); #1;
    penable = 1'b1;
    n = 0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (stall) penable = !(k == 1 || k == 2);
      pe = penable;
      @(posedge pclk); #1;
      if (pe) n++;
      got = pready;
    end
    chk("latency", got ? 64'(n) : 64'hdead, 64'(WS + 1));
    chk("pslverr", 64'(pslverr), 64'(exp_err));
    chk("prdata", 64'(prdata), 64'(ref_rd));
    psel = 1'b0;
    penable = 1'b0;
    @(posedge pclk); #1;
    chk("pready_low", 64'(pready), 64'd0);
    chk("pslverr_low", 64'(pslverr), 64'd0);
  endtask
  initial begin
    logic [31:0] a;
    presetn = 1'b0;
    psel = 1'b0;
    penable = 1'b0;
    pwrite = 1'b0;
    paddr = '0;
    pwdata = '0;
`ifdef APB_RAM_STRB_EN
    pstrb = '0;
`endif
    clear_model();
    repeat (2) @(posedge pclk);
    #1;
    presetn = 1'b1;
    chk("rst_prdata", 64'(prdata), 64'd0);
    chk("rst_pready", 64'(pready), 64'd0);
    chk("rst_pslverr", 64'(pslverr), 64'd0);
    xfer(1'b0, 32'd5, '0, 4'hf, 1'b0);
    xfer(1'b1, 32'd3, 32'hDEADBEEF, 4'hf, 1'b0);
    xfer(1'b0, 32'd3, '0, 4'hf, 1'b0);
    xfer(1'b1, 32'd32, 32'hA5A5A5A5, 4'hf, 1'b0);
    xfer(1'b0, 32'd32, '0, 4'hf, 1'b0);
    xfer(1'b0, 32'hFFFF_FFFF, '0, 4'hf, 1'b1);
    for (int i = 0; i < DEPTH; i++) xfer(1'b0, 32'(i), '0, 4'hf, 1'b0);
    xfer(1'b1, 32'd7, 32'hFFFFFFFF, 4'hf, 1'b0);
    xfer(1'b1, 32'd7, 32'h11223344, 4'b0101, 1'b0);
    xfer(1'b0, 32'd7, '0, 4'hf, 1'b0);
    xfer(1'b1, 32'd9, 32'hCAFEF00D, 4'b0000, 1'b0);
    xfer(1'b0, 32'd9, '0, 4'hf, 1'b1);
    xfer(1'b1, 32'd2, 32'h00000055, 4'hf, 1'b0);
    drive_setup(1'b1, 32'd2, 32'h000000AA, 4'hf);
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0;
    penable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge pclk); #1;
      chk("abort_pready", 64'(pready), 64'd0);
    end
    xfer(1'b0, 32'd2, '0, 4'hf, 1'b0);
    drive_setup(1'b1, 32'd2, 32'h12345678, 4'hf);
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    presetn = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    psel = 1'b0;
    penable = 1'b0;
    clear_model();
    chk("rstabort_prdata", 64'(prdata), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge pclk); #1;
      chk("rstabort_pready", 64'(pready), 64'd0);
    end
    xfer(1'b0, 32'd2, '0, 4'hf, 1'b0);
    xfer(1'b0, 32'd3, '0, 4'hf, 1'b0);
    for (int i = 0; i < 80; i++) begin
      a = 32'($urandom_range(0, DEPTH + 3));
      xfer(1'($urandom_range(0, 1)), a, DW'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < DEPTH; i++) xfer(1'b0, 32'(i), '0, 4'hf, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
